// File: rtl/gate_op_sequencer.sv
// rtl/gate_op_sequencer.sv - drives a gate unit per command and collects results
// Optional sweep of all six opcodes per command: define GATE_SEQ_SWEEP_EN.
module gate_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_a,
    input  logic       cmd_b,
    input  logic [2:0] cmd_op,
`ifdef GATE_SEQ_SWEEP_EN
    input  logic       cmd_sweep,
`endif
    output logic       gates_data1,
    output logic       gates_data2,
    output logic       gates_enable,
    output logic [2:0] gates_op,
    input  logic       gates_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [5:0] rsp_result,
    output logic       rsp_err,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    localparam logic [3:0] HOLD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       a_q;
    logic       b_q;
    logic [2:0] op_q;
    logic       sweep_q;
    logic       sweep_in;

`ifdef GATE_SEQ_SWEEP_EN
    assign sweep_in = cmd_sweep;
`else
    assign sweep_in = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            op_q         <= '0;
            sweep_q      <= 1'b0;
            cmd_ready    <= 1'b0;
            gates_data1  <= 1'b0;
            gates_data2  <= 1'b0;
            gates_enable <= 1'b0;
            gates_op     <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        a_q        <= cmd_a;
                        b_q        <= cmd_b;
                        op_q       <= cmd_op;
                        sweep_q    <= sweep_in;
                        cnt        <= '0;
                        rsp_result <= '0;
                        if (sweep_in || cmd_op <= 3'd5)
                            state <= DRIVE;
                        else
                            state <= RESP;
                    end
                end
                DRIVE: begin
                    // First DRIVE cycle only loads the gate-unit registers.
                    if (!gates_enable) begin
                        gates_enable <= 1'b1;
                        gates_data1  <= a_q;
                        gates_data2  <= b_q;
                        gates_op     <= sweep_q ? 3'd0 : op_q;
                        cnt          <= HOLD;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_result <= rsp_result | (6'(gates_out) << gates_op);
                        if (sweep_q && gates_op != 3'd5) begin
                            gates_op <= gates_op + 3'd1;
                            cnt      <= HOLD;
                        end else begin
                            gates_enable <= 1'b0;
                            gates_data1  <= 1'b0;
                            gates_data2  <= 1'b0;
                            gates_op     <= '0;
                            rsp_valid    <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                RESP: begin
                    // Entered with rsp_valid low only on the illegal-opcode path.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_result <= '0;
                        rsp_err    <= 1'b0;
                        busy       <= 1'b0;
                        cmd_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_op_sequencer.sv
// tb/tb_gate_op_sequencer.sv - directed self-checking bench for gate_op_sequencer
module tb_gate_op_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst4 = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_a = 1'b0;
    logic       cmd_b = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic       cmd_sweep = 1'b0;
    logic       rsp_ready = 1'b0;

    logic       cmd_ready, gates_data1, gates_data2, gates_enable, gates_out;
    logic [2:0] gates_op;
    logic       rsp_valid, rsp_err, busy;
    logic [5:0] rsp_result;

    logic       cmd_ready4, gates_data1_4, gates_data2_4, gates_enable4, gates_out4;
    logic [2:0] gates_op4;
    logic       rsp_valid4, rsp_err4, busy4;
    logic [5:0] rsp_result4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic gate_f(input logic [2:0] op, input logic a, input logic b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~a;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return a ^ b;
            default: return 1'b0;
        endcase
    endfunction

    assign gates_out  = gate_f(gates_op, gates_data1, gates_data2);
    assign gates_out4 = gate_f(gates_op4, gates_data1_4, gates_data2_4);

    gate_op_sequencer #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
`ifdef GATE_SEQ_SWEEP_EN
        .cmd_sweep(cmd_sweep),
`endif
        .gates_data1(gates_data1), .gates_data2(gates_data2), .gates_enable(gates_enable),
        .gates_op(gates_op), .gates_out(gates_out), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    gate_op_sequencer #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst4), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
`ifdef GATE_SEQ_SWEEP_EN
        .cmd_sweep(cmd_sweep),
`endif
        .gates_data1(gates_data1_4), .gates_data2(gates_data2_4), .gates_enable(gates_enable4),
        .gates_op(gates_op4), .gates_out(gates_out4), .rsp_valid(rsp_valid4),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result4), .rsp_err(rsp_err4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command to dut and check the whole transaction with fixed latency.
    task automatic run_cmd(input logic [2:0] op, input logic a, input logic b, input logic sw,
                           input logic [5:0] exp_res, input logic exp_err,
                           input int lat, input int hold);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_sweep = sw; cmd_valid = 1'b1; rsp_ready = 1'b0;
        chk("ready_before_accept", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("ready_after_accept", cmd_ready, 0);
        chk("busy_after_accept", busy, 1);
        chk("enable_setup", gates_enable, 0);
        for (int k = 1; k <= lat; k++) begin
            step();
            if (k < lat) begin
                chk("valid_early", rsp_valid, 0);
                chk("enable_drive", gates_enable, 1);
                chk("op_drive", gates_op, sw ? 3'(k - 1) : op);
            end
        end
        chk("valid_at_latency", rsp_valid, 1);
        chk("result", rsp_result, exp_res);
        chk("err", rsp_err, exp_err);
        chk("enable_resp", gates_enable, 0);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_result", rsp_result, exp_res);
            chk("hold_err", rsp_err, exp_err);
            chk("hold_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("valid_drop", rsp_valid, 0);
        chk("busy_idle", busy, 0);
        chk("ready_idle", cmd_ready, 1);
    endtask

    int acc_n, rsp_n, overlap_n;
    logic acc_s, rsp_s;

    initial begin
        step();
        step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_enable", gates_enable, 0);
        chk("rst_result", rsp_result, 0);
        rst = 1'b0;
        step();
        chk("ready_after_release", cmd_ready, 1);

        run_cmd(3'd1, 1'b1, 1'b0, 1'b0, 6'b000010, 1'b0, 2, 5);
        run_cmd(3'd6, 1'b1, 1'b1, 1'b0, 6'b000000, 1'b1, 1, 0);
        run_cmd(3'd0, 1'b1, 1'b1, 1'b0, 6'b000001, 1'b0, 2, 0);
        run_cmd(3'd2, 1'b0, 1'b1, 1'b0, 6'b000100, 1'b0, 2, 0);
        run_cmd(3'd3, 1'b1, 1'b1, 1'b0, 6'b000000, 1'b0, 2, 0);
        run_cmd(3'd4, 1'b0, 1'b0, 1'b0, 6'b010000, 1'b0, 2, 0);
        run_cmd(3'd5, 1'b1, 1'b0, 1'b0, 6'b100000, 1'b0, 2, 0);
        run_cmd(3'd7, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, 1, 1);
        run_cmd(3'd0, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b0, 2, 0);
`ifdef GATE_SEQ_SWEEP_EN
        run_cmd(3'd7, 1'b1, 1'b0, 1'b1, 6'b101010, 1'b0, 7, 1);
`endif

        // Back-to-back: one command every four edges, never accept on a response edge.
        cmd_op = 3'd5; cmd_a = 1'b1; cmd_b = 1'b0; cmd_sweep = 1'b0;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        acc_n = 0; rsp_n = 0; overlap_n = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            acc_s = cmd_valid && cmd_ready;
            rsp_s = rsp_valid && rsp_ready;
            if (acc_s) acc_n++;
            if (rsp_s) begin
                rsp_n++;
                chk("b2b_result", rsp_result, 6'b100000);
            end
            if (acc_s && rsp_s) overlap_n++;
        end
        cmd_valid = 1'b0;
        step();
        step();
        rsp_ready = 1'b0;
        chk("b2b_accepts", 8'(acc_n), 6);
        chk("b2b_responses", 8'(rsp_n), 6);
        chk("b2b_overlap", 8'(overlap_n), 0);

        // Reset in the second DRIVE cycle of a SETTLE_CYCLES=4 instance.
        rst = 1'b1;
        rst4 = 1'b0;
        step();
        chk("s4_ready", cmd_ready4, 1);
        cmd_op = 3'd0; cmd_a = 1'b1; cmd_b = 1'b1; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        chk("s4_enable_c1", gates_enable4, 1);
        step();
        chk("s4_enable_c2", gates_enable4, 1);
        #1 rst4 = 1'b1;
        #1;
        chk("s4_enable_rst", gates_enable4, 0);
        chk("s4_ready_rst", cmd_ready4, 0);
        chk("s4_busy_rst", busy4, 0);
        step();
        step();
        chk("s4_valid_rst", rsp_valid4, 0);
        rst4 = 1'b0;
        step();
        chk("s4_ready_release", cmd_ready4, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("s4_no_valid", rsp_valid4, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
